// File: rtl/pdm_led_matrix.sv
// Purpose : ROWSxCOLS multiplexed LED matrix scanner with a first-order PDM modulator per LED.
// Latency : a write reaches the pins after the next frame commit, plus the row's slot offset, plus BLANK+1 cycles.
// Backpr. : none. wr_en is always accepted, one write per cycle, and out-of-range addresses are dropped.
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset; clears all state, including the brightness tables
//   wr_en        write strobe
//   wr_addr      LED index = row*COLS + col
//   wr_data      brightness level, 0 = off
//   aled         one-hot active anode row (registered)
//   kled_tri     cathode output enables; bit c = 1 lights LED (row, c)
//   frame_start  one-cycle pulse in the first cycle of row 0 of each new frame
//
// Optional feature: define LED_GAMMA_EN to store (wr_data*wr_data)>>BITS instead of wr_data.
module pdm_led_matrix #(
    parameter  int ROWS  = 4,
    parameter  int COLS  = 4,
    parameter  int BITS  = 10,
    parameter  int DWELL = 1024,
    parameter  int BLANK = 8,
    localparam int AW    = $clog2(ROWS*COLS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [BITS-1:0] wr_data,
    output logic [ROWS-1:0] aled,
    output logic [COLS-1:0] kled_tri,
    output logic            frame_start
);

    localparam int N  = ROWS * COLS;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

    logic [CW-1:0]   r_cnt;
    logic [RW-1:0]   r_row;
    logic [ROWS-1:0] r_aled;
    logic [COLS-1:0] r_kled;
    logic            r_fs;

    // shadow takes writes, active feeds the modulators, acc carries the PDM residue
    logic [BITS-1:0] r_shadow [N];
    logic [BITS-1:0] r_active [N];
    logic [BITS-1:0] r_acc    [N];

    logic            w_slot_end;
    logic            w_commit;
    logic            w_pdm_step;
    logic            w_in_range;
    logic [RW-1:0]   w_row_nxt;
    logic [BITS-1:0] w_wdata;
    logic [BITS-1:0] w_acc_sel [COLS];
    logic [BITS-1:0] w_lvl_sel [COLS];
    logic [BITS:0]   w_sum     [COLS];
    logic [COLS-1:0] w_carry;

    assign w_slot_end = (r_cnt == CW'(DWELL-1));
    assign w_commit   = w_slot_end && (r_row == RW'(ROWS-1));
    // Modulators step from the last blank cycle so the first lit output lands exactly at cnt == BLANK.
    assign w_pdm_step = (r_cnt >= CW'(BLANK-1)) && (r_cnt <= CW'(DWELL-2));
    assign w_in_range = (32'(wr_addr) < 32'(N));

    always_comb begin
        w_row_nxt = r_row;
        if (w_slot_end) begin
            w_row_nxt = (r_row == RW'(ROWS-1)) ? '0 : r_row + 1'b1;
        end
    end

`ifdef LED_GAMMA_EN
    // Square-law curve; the top half of the product keeps the full-scale range.
    logic [2*BITS-1:0] w_sq;
    assign w_sq    = {{BITS{1'b0}}, wr_data} * {{BITS{1'b0}}, wr_data};
    assign w_wdata = w_sq[2*BITS-1:BITS];
`else
    assign w_wdata = wr_data;
`endif

    // One adder per column: select the active row's accumulator and level, then add.
    always_comb begin
        for (int c = 0; c < COLS; c++) begin
            w_acc_sel[c] = '0;
            w_lvl_sel[c] = '0;
            for (int rr = 0; rr < ROWS; rr++) begin
                if (r_row == RW'(rr)) begin
                    w_acc_sel[c] = r_acc[rr*COLS + c];
                    w_lvl_sel[c] = r_active[rr*COLS + c];
                end
            end
            w_sum[c]   = {1'b0, w_acc_sel[c]} + {1'b0, w_lvl_sel[c]};
            w_carry[c] = w_sum[c][BITS];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_row  <= '0;
            r_aled <= ROWS'(1);
            r_kled <= '0;
            r_fs   <= 1'b0;
            for (int i = 0; i < N; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
                r_acc[i]    <= '0;
            end
        end else begin
            r_cnt  <= w_slot_end ? '0 : r_cnt + 1'b1;
            r_row  <= w_row_nxt;
            r_aled <= ROWS'(1) << w_row_nxt;
            r_fs   <= w_commit;
            r_kled <= w_pdm_step ? w_carry : '0;
            for (int i = 0; i < N; i++) begin
                // active samples shadow before this edge's write lands, so a write on
                // the commit edge waits for the following frame.
                if (w_commit) begin
                    r_active[i] <= r_shadow[i];
                end
                if (wr_en && w_in_range && (wr_addr == AW'(i))) begin
                    r_shadow[i] <= w_wdata;
                end
                // Only the scanned row steps; other rows keep their residue.
                if (w_pdm_step && (r_row == RW'(i / COLS))) begin
                    r_acc[i] <= w_sum[i % COLS][BITS-1:0];
                end
            end
        end
    end

    assign aled        = r_aled;
    assign kled_tri    = r_kled;
    assign frame_start = r_fs;

endmodule

// File: tb/tb_pdm_led_matrix.sv
// Purpose : self-checking bench for pdm_led_matrix (default geometry plus a 3-row, short-slot instance).
// Latency : expected outputs are queued at each rising edge and compared at the following falling edge.
// Backpr. : none.
module tb_pdm_led_matrix;

    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int BITS  = 10;
    localparam int DWELL = 1024;
    localparam int BLANK = 8;
    localparam int N     = ROWS * COLS;
    localparam int FULL  = 1 << BITS;
    localparam int STEPS = DWELL - BLANK;

    // A fresh accumulator stepped STEPS times lights floor(STEPS*level/2^BITS) times.
`ifdef LED_GAMMA_EN
    localparam int EXP_512  = (STEPS * ((512 * 512) >> BITS)) / FULL;
    localparam int EXP_1023 = (STEPS * ((1023 * 1023) >> BITS)) / FULL;
`else
    localparam int EXP_512  = (STEPS * 512) / FULL;
    localparam int EXP_1023 = (STEPS * 1023) / FULL;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            wr_en;
    logic [3:0]      wr_addr;
    logic [BITS-1:0] wr_data;
    logic [ROWS-1:0] aled;
    logic [COLS-1:0] kled_tri;
    logic            frame_start;

    logic            rst3;
    logic            wr_en3;
    logic [3:0]      wr_addr3;
    logic [BITS-1:0] wr_data3;
    logic [2:0]      aled3;
    logic [3:0]      kled3;
    logic            fs3;

    always #5 clk = ~clk;

    pdm_led_matrix #(.ROWS(ROWS), .COLS(COLS), .BITS(BITS), .DWELL(DWELL), .BLANK(BLANK)) u_dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .aled(aled), .kled_tri(kled_tri), .frame_start(frame_start)
    );

    pdm_led_matrix #(.ROWS(3), .COLS(4), .BITS(BITS), .DWELL(16), .BLANK(2)) u_dut3 (
        .clk(clk), .rst(rst3), .wr_en(wr_en3), .wr_addr(wr_addr3), .wr_data(wr_data3),
        .aled(aled3), .kled_tri(kled3), .frame_start(fs3)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model state, post-edge view.
    int         m_cnt, m_r;
    int         m_sh [N];
    int         m_act[N];
    int         m_acc[N];
    logic [3:0] m_aled;
    logic [3:0] m_kled;
    logic       m_fs;

    function automatic int gam(input int d);
`ifdef LED_GAMMA_EN
        return (d * d) >> BITS;
`else
        return d;
`endif
    endfunction

    task automatic model_step();
        logic [3:0] kn;
        bit         commit;
        int         s, idx;
        if (rst) begin
            m_cnt = 0;
            m_r   = 0;
            for (int i = 0; i < N; i++) begin
                m_sh[i] = 0; m_act[i] = 0; m_acc[i] = 0;
            end
            m_aled = 4'b0001;
            m_kled = 4'b0000;
            m_fs   = 1'b0;
        end else begin
            commit = (m_cnt == DWELL-1) && (m_r == ROWS-1);
            kn = 4'b0000;
            if (m_cnt >= BLANK-1 && m_cnt <= DWELL-2) begin
                for (int c = 0; c < COLS; c++) begin
                    idx = m_r*COLS + c;
                    s = m_acc[idx] + m_act[idx];
                    m_acc[idx] = s % FULL;
                    kn[c] = (s >= FULL);
                end
            end
            if (commit) begin
                for (int i = 0; i < N; i++) m_act[i] = m_sh[i];
            end
            if (wr_en && int'(wr_addr) < N) m_sh[int'(wr_addr)] = gam(int'(wr_data));
            m_fs = commit;
            if (m_cnt == DWELL-1) begin
                m_cnt = 0;
                m_r   = (m_r + 1) % ROWS;
            end else begin
                m_cnt++;
            end
            m_aled = 4'(1 << m_r);
            m_kled = kn;
        end
    endtask

    logic [8:0] sb[$];
    int         on_cnt [N];
    int         last   [N];
    bit         saw_fs;

    // One clock: model the edge and queue its expected outputs, then check the DUT at the falling edge.
    task automatic tick();
        logic [8:0] e;
        @(posedge clk);
        model_step();
        sb.push_back({m_aled, m_kled, m_fs});
        @(negedge clk);
        e = sb.pop_front();
        chk("cycle", 32'({aled, kled_tri, frame_start}), 32'(e));
        saw_fs = e[0];
        if (e[0]) begin
            last = on_cnt;
            for (int i = 0; i < N; i++) on_cnt[i] = 0;
        end
        for (int c = 0; c < COLS; c++) begin
            if (kled_tri[c]) on_cnt[m_r*COLS + c]++;
        end
    endtask

    task automatic wait_pos(input int r, input int c);
        int k = 0;
        while (!(m_r == r && m_cnt == c) && k < 2*ROWS*DWELL) begin
            tick();
            k++;
        end
        if (k >= 2*ROWS*DWELL) chk("wait_pos_timeout", 0, 1);
    endtask

    task automatic wait_fs();
        int k = 0;
        saw_fs = 1'b0;
        while (!saw_fs && k < 2*ROWS*DWELL) begin
            tick();
            k++;
        end
        if (!saw_fs) chk("wait_fs_timeout", 0, 1);
    endtask

    task automatic wr(input int a, input int d);
        wr_en = 1'b1; wr_addr = 4'(a); wr_data = BITS'(d);
        tick();
        wr_en = 1'b0;
    endtask

    function automatic int sum_except(input int a, input int b, input int c);
        int s = 0;
        for (int i = 0; i < N; i++) if (i != a && i != b && i != c) s += last[i];
        return s;
    endfunction

    logic [3:0] or3 [3];
    initial for (int i = 0; i < 3; i++) or3[i] = 4'b0000;
    always @(negedge clk) begin
        if (!rst3) begin
            for (int rr = 0; rr < 3; rr++) if (aled3[rr]) or3[rr] = or3[rr] | kled3;
        end
    end

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rst3 = 1'b1; wr_en3 = 1'b0; wr_addr3 = '0; wr_data3 = '0;
        for (int i = 0; i < N; i++) begin on_cnt[i] = 0; last[i] = 0; end

        tick();
        tick();
        chk("rst_aled", 32'(aled), 32'h1);
        chk("rst_kled", 32'(kled_tri), 32'h0);
        chk("rst_fs", 32'(frame_start), 32'h0);
        rst = 1'b0; rst3 = 1'b0;
        tick();
        chk("no_fs_after_rst", 32'(frame_start), 32'h0);

        // 3-row instance: addr 11 is row 2 col 3; 12..15 lie beyond the matrix.
        for (int a = 11; a < 16; a++) begin
            wr_en3 = 1'b1; wr_addr3 = 4'(a); wr_data3 = BITS'(1023);
            tick();
        end
        wr_en3 = 1'b0;

        // Mid-frame writes become visible only in the next frame.
        wait_pos(1, 976);
        wr(5, 512);
        wr(0, 1023);
        wr(3, 0);

        wait_fs();
        chk("f0_dark", 32'(sum_except(-1, -1, -1)), 32'h0);

        wait_fs();
        chk("f1_addr5", 32'(last[5]), 32'(EXP_512));
        chk("f1_addr0", 32'(last[0]), 32'(EXP_1023));
        chk("f1_addr3", 32'(last[3]), 32'h0);
        chk("f1_others", 32'(sum_except(0, 3, 5)), 32'h0);

        // Write one cycle before the commit edge, then on it.
        wait_pos(ROWS-1, DWELL-2);
        wr(9, 512);
        wr(10, 512);
        chk("f2_seen", 32'(saw_fs), 32'h1);
        chk("f2_addr5", 32'(last[5]), 32'(EXP_512));
        chk("f2_addr9", 32'(last[9]), 32'h0);

        wait_fs();
        chk("f3_addr9", 32'(last[9]), 32'(EXP_512));
        chk("f3_addr10", 32'(last[10]), 32'h0);

        wait_fs();
        chk("f4_addr10", 32'(last[10]), 32'(EXP_512));
        chk("f4_addr9", 32'(last[9]), 32'(EXP_512));

        // Reset mid-slot with a write in the same cycle; the write must be dropped.
        wait_pos(2, 500);
        rst = 1'b1;
        wr_en = 1'b1; wr_addr = 4'd1; wr_data = BITS'(1023);
        tick();
        rst = 1'b0; wr_en = 1'b0;
        for (int i = 0; i < N; i++) on_cnt[i] = 0;
        chk("midrst_aled", 32'(aled), 32'h1);
        chk("midrst_kled", 32'(kled_tri), 32'h0);
        wait_fs();
        chk("postrst_dark", 32'(sum_except(-1, -1, -1)), 32'h0);

        chk("r3_row0", 32'(or3[0]), 32'h0);
        chk("r3_row1", 32'(or3[1]), 32'h0);
        chk("r3_row2", 32'(or3[2]), 32'h8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
